fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- PC-generation and fetch stage that sits directly upstream of the synchronous instruction memory.
- Drives the word-aligned byte address into memory and tags the 1-cycle-latency read data with its PC and a valid bit.
- Supports decode-side stall (backpressure) via an internal hold register, and a redirect (branch/jump) that flushes the in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high reset.
- stall_i, input, 1, downstream cannot accept this cycle; hold current output.
- redirect_i, input, 1, load redirect_pc_i and flush the in-flight fetch.
- redirect_pc_i, input, 32, redirect target byte address.
- imem_addr_o, output, 32, byte address to instruction memory; driven from a register, no combinational input path.
- imem_data_i, input, 32, memory read data, valid the cycle after the address was presented.
- instr_o, output, 32, fetched instruction; NOP (32'h0000_0013) whenever valid_o=0.
- pc_o, output, 32, PC of instr_o.
- valid_o, output, 1, instr_o/pc_o hold a live instruction.

Behaviour:
- State:
  - pc_q: the address presented this cycle; imem_addr_o = pc_q.
  - pc_resp_q: PC of the data returning this cycle.
  - resp_vld_q: valid bit for the returning data.
  - hold_q (32b) and hold_vld_q: captured instruction held during stall.
- Reset, synchronous:
  - pc_q=RESET_PC, pc_resp_q=0, resp_vld_q=0, hold_vld_q=0, hold_q=0.
  - Outputs during reset: imem_addr_o=RESET_PC, valid_o=0, instr_o=NOP, pc_o=0.
- Cycle after reset release:
  - valid_o=0; memory is still returning its reset 0.
  - On the next cycle, valid_o=1, pc_o=RESET_PC, instr_o=mem[RESET_PC].
- Advance (no stall, no redirect):
  - pc_q<=pc_q+PC_STEP; pc_resp_q<=pc_q; resp_vld_q<=1; hold_vld_q<=0.
  - Throughput is 1 instruction/cycle; latency is 1 cycle from address to instr_o.
- Output select:
  - instr_o = hold_vld_q ? hold_q : imem_data_i, forced to NOP when valid_o=0.
  - valid_o = resp_vld_q; pc_o = pc_resp_q.
- Stall (stall_i=1, redirect_i=0):
  - pc_q, pc_resp_q and resp_vld_q hold.
  - First stall cycle (hold_vld_q=0): hold_q<=imem_data_i, hold_vld_q<=1.
  - Later stall cycles keep hold_q. Outputs stay bit-identical for the entire stall.
  - Memory keeps reading mem[pc_q], so the data for the next instruction is ready on release.
- Stall release: the held instruction is consumed that cycle and the normal advance rule applies; hold_vld_q clears.
- Redirect (redirect_i=1):
  - Has priority over stall.
  - pc_q<=redirect_pc_i with bits [1:0] forced to 0; resp_vld_q<=0; hold_vld_q<=0.
  - Next cycle: valid_o=0 (bubble). The cycle after: target instruction is valid.
  - Exactly one bubble per redirect.
- Back-to-back redirects: the last one wins; valid_o stays 0 until one cycle after the final redirect.
- Wrap-around: pc_q+PC_STEP wraps modulo 2^32 without a flag.
- Reset mid-operation (including mid-stall): drops all in-flight and held state. Reset has priority over redirect and stall.

Optional Feature:
- Macro: FETCH_MISALIGN_EXC_EN.
- Defined:
  - Adds output misalign_exc_o (1b).
  - A redirect with redirect_pc_i[1:0]!=0 sets a sticky flag.
  - While the flag is set: resp_vld_q is forced to 0, pc_q does not advance, and misalign_exc_o=1.
  - The flag clears only on reset or an aligned redirect.
- Undefined:
  - No port.
  - Low address bits are silently masked as described under Redirect.

Decomposition:
- Shared package rv_pkg:
  - XLEN=32, ILEN=32.
  - NOP_INSTR=32'h0000_0013.
  - PC_ALIGN_MASK=32'hFFFF_FFFC.
  - typedef logic [XLEN-1:0] addr_t; typedef logic [ILEN-1:0] instr_t.
- One sub-module is natural: fetch_hold_buf.
  - Contents: hold_q/hold_vld_q capture logic and the output mux.
  - Ports: clk, reset, stall, flush, data_in, data_out.

Test Plan:
1. Reset release, memory preloaded with word i = 32'h1000_0000+i: valid_o=0 for one cycle, then pc_o=0,4,8,… with instr_o=32'h1000_0000,…_0001,…_0002 on consecutive cycles.
2. stall_i=1 for 3 cycles while pc_o=8: pc_o=8 and instr_o=32'h1000_0002 are stable for all 3 cycles; imem_addr_o holds 12; after release the sequence resumes 12, 16 with no gap or duplicate.
3. redirect_i=1, redirect_pc_i=32'h40 while streaming: next cycle valid_o=0 and instr_o=NOP; the following cycle pc_o=32'h40, instr_o=mem[16].
4. redirect_i and stall_i together while holding: the redirect wins, the hold is dropped, one bubble, then pc_o=target. Also: redirect_pc_i=32'h42 executes at pc_o=32'h40 with the macro off; with the macro on, misalign_exc_o=1 and valid_o stays 0.
5. Reset asserted during a 2-cycle stall: the next cycle shows valid_o=0, instr_o=NOP and imem_addr_o=RESET_PC; the stream restarts from RESET_PC.
6. Start from RESET_PC=32'hFFFF_FFF8 with no stalls: pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap, no error).

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V fetch-path definitions: data widths, the canonical NOP encoding,
// the word-alignment mask for PCs, and address/instruction typedefs.
package rv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   typedef logic [XLEN-1:0] addr_t;
   typedef logic [ILEN-1:0] instr_t;

   // addi x0, x0, 0
   localparam instr_t NOP_INSTR     = 32'h0000_0013;
   localparam addr_t  PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_hold_buf.sv
// Stall hold buffer for the fetch stage. On the first stalled cycle it captures
// the instruction returning from memory so the output stays stable while memory
// moves on to the next word. It also provides the held/live output mux.
//
// Ports:
//   clk      - clock, posedge
//   reset    - synchronous active-high reset, clears the held entry
//   stall    - downstream backpressure
//   flush    - drop any held entry (redirect)
//   data_in  - memory read data
//   data_out - held instruction if one is held, otherwise data_in
module fetch_hold_buf
   import rv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            flush,
   input  logic [ILEN-1:0] data_in,
   output logic [ILEN-1:0] data_out
);

   instr_t hold_q, hold_d;
   logic   hold_vld_q, hold_vld_d;

   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (flush || !stall) begin
         // Held word is consumed on release, or discarded by a redirect.
         hold_vld_d = 1'b0;
      end else if (!hold_vld_q) begin
         hold_d     = data_in;
         hold_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

   assign data_out = hold_vld_q ? hold_q : data_in;

endmodule

// File: rtl/fetch_unit.sv
// PC generation and fetch stage in front of a 1-cycle synchronous instruction
// memory. Presents a registered word-aligned address, tags the returning data
// with its PC and a valid bit, holds its output under stall, and inserts one
// bubble per redirect.
//
// Optional feature macro: FETCH_MISALIGN_EXC_EN. When defined, a redirect to a
// non-word-aligned target raises a sticky misalign_exc_o and freezes fetch
// until reset or an aligned redirect. When undefined, low bits are masked.
//
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   stall_i             - downstream cannot accept; hold outputs
//   redirect_i          - load redirect_pc_i, flush in-flight fetch
//   redirect_pc_i       - redirect target byte address
//   imem_addr_o         - registered byte address to instruction memory
//   imem_data_i         - memory read data, one cycle after the address
//   instr_o, pc_o       - fetched instruction (NOP when invalid) and its PC
//   valid_o             - instr_o/pc_o hold a live instruction
//   misalign_exc_o      - sticky misaligned-redirect flag (macro only)
module fetch_unit
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o
`ifdef FETCH_MISALIGN_EXC_EN
   ,
   output logic        misalign_exc_o
`endif
);

   addr_t  pc_q, pc_d;
   addr_t  pc_resp_q, pc_resp_d;
   logic   resp_vld_q, resp_vld_d;
   instr_t sel_instr;
   logic   frozen;

`ifdef FETCH_MISALIGN_EXC_EN
   logic misalign_q, misalign_d;

   always_comb begin
      misalign_d = misalign_q;
      if (redirect_i) misalign_d = |redirect_pc_i[1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end

   assign frozen         = misalign_q;
   assign misalign_exc_o = misalign_q;
`else
   assign frozen = 1'b0;
`endif

   always_comb begin
      pc_d       = pc_q;
      pc_resp_d  = pc_resp_q;
      resp_vld_d = resp_vld_q;
      if (redirect_i) begin
         // Redirect beats stall; the word in flight is dropped (one bubble).
         pc_d       = redirect_pc_i & PC_ALIGN_MASK;
         resp_vld_d = 1'b0;
      end else if (stall_i) begin
         // Everything holds; memory keeps re-reading pc_q.
      end else if (frozen) begin
         resp_vld_d = 1'b0;
      end else begin
         pc_d       = pc_q + 32'(PC_STEP);
         pc_resp_d  = pc_q;
         resp_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         pc_resp_q  <= '0;
         resp_vld_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pc_resp_q  <= pc_resp_d;
         resp_vld_q <= resp_vld_d;
      end
   end

   fetch_hold_buf u_hold_buf (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall_i),
      .flush    (redirect_i),
      .data_in  (imem_data_i),
      .data_out (sel_instr)
   );

   assign imem_addr_o = pc_q;
   assign valid_o     = resp_vld_q;
   assign pc_o        = pc_resp_q;
   assign instr_o     = resp_vld_q ? sel_instr : NOP_INSTR;

endmodule
